alu_issue_ctrl: RTL and testbench

//  Multi-cycle issue/sequencer that drives the Alu_Top opcode/func_field/A/B inputs and consumes result/zero.

---
 rtl/alu_issue_ctrl_if.sv | 28 ++
 rtl/alu_issue_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Issue-side bundle of alu_issue_ctrl: instruction handshake, Alu_Top
// operand/result pins and the load-memory request/response pins.
// master = the issue controller, slave = its environment (fetch, ALU, memory).
interface alu_issue_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  alu_opcode;
    logic [5:0]  alu_func;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  instr_valid, instr, alu_result, alu_zero, mem_rvalid, mem_rdata,
        output instr_ready, alu_opcode, alu_func, alu_a, alu_b, mem_req, mem_addr
    );

    modport slave (
        output instr_valid, instr, alu_result, alu_zero, mem_rvalid, mem_rdata,
        input  instr_ready, alu_opcode, alu_func, alu_a, alu_b, mem_req, mem_addr
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle MIPS issue sequencer in front of Alu_Top.
// Executes add/and/slt, lw and beq one instruction at a time against a local
// 32x32 register file. Optional feature macro: RETIRE_CNT_EN adds the
// retire_cnt output (WB completions plus beq completions).
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | instr_ready high, waiting for an instruction word
// S_DECODE   | classify word, read registers, register ALU operands
// S_EXEC     | capture ALU result; branch outcome or load address
// S_MEM_WAIT | load outstanding, timeout down-counter running
// S_WB       | write result into destination register
module alu_issue_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.master bus,
    output logic             branch_taken,
    output logic [31:0]      branch_offset,
    output logic             illegal,
    output logic             busy,
    input  logic [4:0]       dbg_raddr,
    output logic [31:0]      dbg_rdata
`ifdef RETIRE_CNT_EN
    ,
    output logic [31:0]      retire_cnt
`endif
);

    // Loaded on entry to MEM_WAIT; zero marks the last allowed wait cycle.
    localparam logic [7:0] TMR_LOAD = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM_WAIT,
        S_WB
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] instr_q;
    logic [31:0] regs [32];
    logic [31:0] wb_data;
    logic [4:0]  wb_dest;
    logic [7:0]  tmr;

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_se;
    logic        is_rtype;
    logic        is_lw;
    logic        is_beq;
    logic        supported;
    logic        tmr_expire;

    // Field extraction is from the latched word, which stays stable until the
    // next accept, so DECODE and EXEC both classify from the same source.
    assign op        = instr_q[31:26];
    assign rs        = instr_q[25:21];
    assign rt        = instr_q[20:16];
    assign rd        = instr_q[15:11];
    assign fn        = instr_q[5:0];
    assign imm_se    = {{16{instr_q[15]}}, instr_q[15:0]};
    assign is_rtype  = (op == 6'h00) && ((fn == 6'h20) || (fn == 6'h24) || (fn == 6'h2A));
    assign is_lw     = (op == 6'h23);
    assign is_beq    = (op == 6'h04);
    assign supported = is_rtype || is_lw || is_beq;

    // Data arriving on the final wait cycle takes priority over the timeout.
    assign tmr_expire = (state == S_MEM_WAIT) && !bus.mem_rvalid && (tmr == 8'd0);

    assign bus.instr_ready = (state == S_IDLE);
    assign busy            = (state != S_IDLE);
    assign dbg_rdata       = (dbg_raddr == 5'd0) ? 32'd0 : regs[dbg_raddr];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (bus.instr_valid) state_nxt = S_DECODE;
            S_DECODE:   state_nxt = supported ? S_EXEC : S_IDLE;
            S_EXEC: begin
                if (is_rtype)   state_nxt = S_WB;
                else if (is_lw) state_nxt = S_MEM_WAIT;
                else            state_nxt = S_IDLE;
            end
            S_MEM_WAIT: begin
                if (bus.mem_rvalid)   state_nxt = S_WB;
                else if (tmr_expire)  state_nxt = S_IDLE;
            end
            S_WB:       state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Latch the instruction word on handshake.
    always_ff @(posedge clk) begin
        if (rst)                                  instr_q <= '0;
        else if (state == S_IDLE && bus.instr_valid) instr_q <= bus.instr;
    end

    // ALU operands are issued in DECODE and held until the next issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.alu_opcode <= '0;
            bus.alu_func   <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
        end else if (state == S_DECODE && supported) begin
            bus.alu_opcode <= op;
            bus.alu_func   <= is_rtype ? fn : 6'h00;
            bus.alu_a      <= regs[rs];
            bus.alu_b      <= is_lw ? imm_se : regs[rt];
        end
    end

    // Result capture, load request and writeback staging.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
            wb_data      <= '0;
            wb_dest      <= '0;
        end else begin
            case (state)
                S_EXEC: begin
                    wb_data <= bus.alu_result;
                    wb_dest <= is_lw ? rt : rd;
                    if (is_lw) begin
                        bus.mem_addr <= bus.alu_result;
                        bus.mem_req  <= 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    if (bus.mem_rvalid) begin
                        wb_data     <= bus.mem_rdata;
                        bus.mem_req <= 1'b0;
                    end else if (tmr_expire) begin
                        bus.mem_req <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Load timeout down-counter.
    always_ff @(posedge clk) begin
        if (rst)                                        tmr <= 8'd0;
        else if (state == S_EXEC && is_lw)              tmr <= TMR_LOAD;
        else if (state == S_MEM_WAIT && !bus.mem_rvalid && tmr != 8'd0) tmr <= tmr - 8'd1;
    end

    // Single-cycle status pulses: branch outcome and illegal/timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_taken  <= 1'b0;
            branch_offset <= '0;
            illegal       <= 1'b0;
        end else begin
            branch_taken <= 1'b0;
            illegal      <= (state == S_DECODE && !supported) || tmr_expire;
            if (state == S_EXEC && is_beq) begin
                branch_taken  <= bus.alu_zero;
                branch_offset <= {imm_se[29:0], 2'b00};
            end
        end
    end

    // Register file; R0 is never written so it always reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (state == S_WB && wb_dest != 5'd0) begin
            regs[wb_dest] <= wb_data;
        end
    end

`ifdef RETIRE_CNT_EN
    // Retired-instruction counter: every WB and every completed beq.
    always_ff @(posedge clk) begin
        if (rst) retire_cnt <= '0;
        else if (state == S_WB || (state == S_EXEC && is_beq)) retire_cnt <= retire_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        illegal;
    logic        busy;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
`ifdef RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    alu_issue_ctrl_if bus();

    alu_issue_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .illegal       (illegal),
        .busy          (busy),
        .dbg_raddr     (dbg_raddr),
        .dbg_rdata     (dbg_rdata)
`ifdef RETIRE_CNT_EN
        ,
        .retire_cnt    (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural Alu_Top.
    always_comb begin
        bus.alu_result = 32'd0;
        case (bus.alu_opcode)
            6'h00: case (bus.alu_func)
                6'h20:   bus.alu_result = bus.alu_a + bus.alu_b;
                6'h24:   bus.alu_result = bus.alu_a & bus.alu_b;
                6'h2A:   bus.alu_result = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
                default: bus.alu_result = 32'd0;
            endcase
            6'h23:   bus.alu_result = bus.alu_a + bus.alu_b;
            6'h04:   bus.alu_result = bus.alu_a - bus.alu_b;
            default: bus.alu_result = 32'd0;
        endcase
        bus.alu_zero = (bus.alu_result == 32'd0);
    end

    typedef struct {
        logic [31:0] instr;
        int          lat;     // mem_rvalid k cycles into MEM_WAIT; -1 = never
        logic [31:0] rdata;
        logic        wr;
        logic [4:0]  dest;
        logic [31:0] val;
        logic        taken;
        logic [31:0] off;
        int          ill;
        int          done;    // negedges after accept until instr_ready
        int          mreq;    // cycles mem_req high
        logic [31:0] maddr;
        logic        ret;
    } rec_t;

    int          checks = 0;
    int          failures = 0;
    int          exp_ret = 0;
    logic [31:0] mregs [32];
    rec_t        tbl [15];

    function automatic rec_t mk(input logic [31:0] ins, input int lat, input logic [31:0] rdata,
                                input logic wr, input logic [4:0] dest, input logic [31:0] val,
                                input logic taken, input logic [31:0] off, input int ill,
                                input int done, input int mreq, input logic [31:0] maddr,
                                input logic ret);
        rec_t r;
        r.instr = ins; r.lat = lat; r.rdata = rdata; r.wr = wr; r.dest = dest; r.val = val;
        r.taken = taken; r.off = off; r.ill = ill; r.done = done; r.mreq = mreq;
        r.maddr = maddr; r.ret = ret;
        return r;
    endfunction

    // Reference model: architectural effect of one instruction.
    function automatic rec_t model(input logic [31:0] ins, input int lat, input logic [31:0] rdata);
        logic [5:0]  op = ins[31:26];
        logic [5:0]  fn = ins[5:0];
        logic [31:0] a  = mregs[ins[25:21]];
        logic [31:0] b  = mregs[ins[20:16]];
        logic [31:0] se = {{16{ins[15]}}, ins[15:0]};
        if (op == 6'h00 && fn == 6'h20) return mk(ins, lat, rdata, 1, ins[15:11], a + b, 0, 0, 0, 4, 0, 0, 1);
        if (op == 6'h00 && fn == 6'h24) return mk(ins, lat, rdata, 1, ins[15:11], a & b, 0, 0, 0, 4, 0, 0, 1);
        if (op == 6'h00 && fn == 6'h2A)
            return mk(ins, lat, rdata, 1, ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0, 0, 0, 0, 4, 0, 0, 1);
        if (op == 6'h23) begin
            if (lat >= 0 && lat < T) return mk(ins, lat, rdata, 1, ins[20:16], rdata, 0, 0, 0, 5 + lat, lat + 1, a + se, 1);
            return mk(ins, lat, rdata, 0, 0, 0, 0, 0, 1, 3 + T, T, a + se, 0);
        end
        if (op == 6'h04) return mk(ins, lat, rdata, 0, 0, 0, (a == b), se * 4, 0, 3, 0, 0, 1);
        return mk(ins, lat, rdata, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic sweep(input string tag);
        int          bad = -1;
        logic [31:0] got = 0;
        logic [31:0] want = 0;
        for (int k = 0; k < 32; k++) begin
            dbg_raddr = 5'(k);
            #1;
            if (dbg_rdata !== mregs[k] && bad < 0) begin
                bad = k; got = dbg_rdata; want = mregs[k];
            end
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s regfile R%0d actual=0x%08h required=0x%08h", tag, bad, got, want);
        end
        @(negedge clk);
    endtask

    task automatic run_rec(input rec_t r);
        int          done = 0, mreq_n = 0, ill_n = 0, tk_n = 0, wait_n = 0;
        logic [31:0] maddr = 0, off = 0;
        logic        unstable = 0;
        logic [5:0]  op = r.instr[31:26];
        logic [5:0]  fn = r.instr[5:0];
        logic        sup;
        logic [31:0] ea, eb;
        string       tag;
        tag = $sformatf("%08h", r.instr);
        sup = (op == 6'h23) || (op == 6'h04) ||
              (op == 6'h00 && (fn == 6'h20 || fn == 6'h24 || fn == 6'h2A));
        ea  = mregs[r.instr[25:21]];
        eb  = (op == 6'h23) ? {{16{r.instr[15]}}, r.instr[15:0]} : mregs[r.instr[20:16]];

        while (!bus.instr_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        bus.instr       = r.instr;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr       = $urandom();
        for (int i = 1; i <= 400 && done == 0; i++) begin
            if (bus.mem_req) begin
                mreq_n++;
                if (mreq_n == 1) maddr = bus.mem_addr;
                else if (bus.mem_addr !== maddr) unstable = 1'b1;
            end
            if (branch_taken) begin tk_n++; off = branch_offset; end
            if (illegal) ill_n++;
            if (bus.instr_ready) done = i;
            if (i <= 2) begin
                bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0_0000 | 32'(i);
            end else if (bus.mem_req && mreq_n - 1 == r.lat) begin
                bus.mem_rvalid = 1'b1; bus.mem_rdata = r.rdata;
            end else begin
                bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom();
            end
            if (done == 0) @(negedge clk);
        end
        bus.mem_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (branch_taken) tk_n++;
            if (illegal) ill_n++;
            if (bus.mem_req) mreq_n++;
        end

        chk({tag, " done_cycle"}, 32'(done), 32'(r.done));
        chk({tag, " branch_pulses"}, 32'(tk_n), r.taken ? 32'd1 : 32'd0);
        if (r.taken) chk({tag, " branch_offset"}, off, r.off);
        chk({tag, " illegal_pulses"}, 32'(ill_n), 32'(r.ill));
        chk({tag, " mem_req_cycles"}, 32'(mreq_n), 32'(r.mreq));
        if (r.mreq > 0) begin
            chk({tag, " mem_addr"}, maddr, r.maddr);
            chk({tag, " mem_addr_stable"}, 32'(unstable), 32'd0);
        end
        if (sup) begin
            chk({tag, " alu_opcode"}, 32'(bus.alu_opcode), 32'(op));
            chk({tag, " alu_func"}, 32'(bus.alu_func), (op == 6'h00) ? 32'(fn) : 32'd0);
            chk({tag, " alu_a"}, bus.alu_a, ea);
            chk({tag, " alu_b"}, bus.alu_b, eb);
        end
        if (r.wr && r.dest != 5'd0) mregs[r.dest] = r.val;
        if (r.ret) exp_ret++;
        sweep(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = 32'd0;
        dbg_raddr       = 5'd0;
        for (int k = 0; k < 32; k++) mregs[k] = 32'd0;

        //                 instr        lat rdata         wr d  val           tk off           ill done mreq maddr      ret
        tbl[0]  = mk(32'h8C010000,  2, 32'h00002222,  1, 1, 32'h00002222, 0, 0,            0, 7,  3,  32'h0,        1);
        tbl[1]  = mk(32'h8C020004,  1, 32'h00001111,  1, 2, 32'h00001111, 0, 0,            0, 6,  2,  32'h4,        1);
        tbl[2]  = mk(32'h00221820,  0, 0,             1, 3, 32'h00003333, 0, 0,            0, 4,  0,  0,            1);
        tbl[3]  = mk(32'h00222024,  0, 0,             1, 4, 32'h00000000, 0, 0,            0, 4,  0,  0,            1);
        tbl[4]  = mk(32'h0041282A,  0, 0,             1, 5, 32'h00000001, 0, 0,            0, 4,  0,  0,            1);
        tbl[5]  = mk(32'h10210003,  0, 0,             0, 0, 0,            1, 32'h0000000C, 0, 3,  0,  0,            1);
        tbl[6]  = mk(32'h10220003,  0, 0,             0, 0, 0,            0, 0,            0, 3,  0,  0,            1);
        tbl[7]  = mk(32'h1000FFFF,  0, 0,             0, 0, 0,            1, 32'hFFFFFFFC, 0, 3,  0,  0,            1);
        tbl[8]  = mk(32'hFC000000,  0, 0,             0, 0, 0,            0, 0,            1, 2,  0,  0,            0);
        tbl[9]  = mk(32'h00221822,  0, 0,             0, 0, 0,            0, 0,            1, 2,  0,  0,            0);
        tbl[10] = mk(32'h00220020,  0, 0,             1, 0, 32'h00003333, 0, 0,            0, 4,  0,  0,            1);
        tbl[11] = mk(32'h8C010008, -1, 32'h0000DEAD,  0, 0, 0,            0, 0,            1, 19, 16, 32'h8,        0);
        tbl[12] = mk(32'h8C03FFFC,  0, 32'hA5A5A5A5,  1, 3, 32'hA5A5A5A5, 0, 0,            0, 5,  1,  32'hFFFFFFFC, 1);
        tbl[13] = mk(32'h8C040010, 15, 32'h12345678,  1, 4, 32'h12345678, 0, 0,            0, 20, 16, 32'h10,       1);
        tbl[14] = mk(32'h8C050010, 16, 32'h87654321,  0, 0, 0,            0, 0,            1, 19, 16, 32'h10,       0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset instr_ready", 32'(bus.instr_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset mem_req", 32'(bus.mem_req), 32'd0);
        chk("reset mem_addr", bus.mem_addr, 32'd0);
        chk("reset illegal", 32'(illegal), 32'd0);
        chk("reset branch_taken", 32'(branch_taken), 32'd0);
        chk("reset branch_offset", branch_offset, 32'd0);
        chk("reset alu_opcode_func", {20'd0, bus.alu_opcode, bus.alu_func}, 32'd0);
        chk("reset alu_a", bus.alu_a, 32'd0);
        chk("reset alu_b", bus.alu_b, 32'd0);
        sweep("reset");

        for (int n = 0; n < 15; n++) run_rec(tbl[n]);

        // Reset while a load is outstanding.
        bus.instr       = 32'h8C060000;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        for (int k = 0; k < 10 && !bus.mem_req; k++) @(negedge clk);
        chk("midrst mem_req_before", 32'(bus.mem_req), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst mem_req", 32'(bus.mem_req), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst instr_ready", 32'(bus.instr_ready), 32'd1);
        chk("midrst illegal", 32'(illegal), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 32; k++) mregs[k] = 32'd0;
        exp_ret = 0;
        sweep("midrst");

        // Randomized instruction stream against the reference model.
        for (int n = 0; n < 60; n++) begin
            int          sel, lat;
            logic [5:0]  op, fn;
            logic [4:0]  rs, rt, rd;
            logic [15:0] imm;
            sel = $urandom_range(0, 9);
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            imm = 16'($urandom());
            lat = $urandom_range(0, 6);
            op  = 6'h00;
            fn  = 6'h20;
            case (sel)
                0, 1, 2: begin op = 6'h23; imm = 16'($urandom_range(0, 255)); end
                3: begin op = 6'h23; lat = ($urandom_range(0, 1) != 0) ? -1 : T - 1; end
                4: fn = 6'h20;
                5: fn = 6'h24;
                6: fn = 6'h2A;
                7, 8: begin op = 6'h04; if ($urandom_range(0, 1) != 0) rt = rs; end
                default: begin
                    if ($urandom_range(0, 1) != 0) begin
                        op = 6'($urandom_range(1, 63));
                        if (op == 6'h23 || op == 6'h04) op = 6'h3F;
                    end else begin
                        fn = 6'($urandom_range(0, 63));
                        if (fn == 6'h20 || fn == 6'h24 || fn == 6'h2A) fn = 6'h22;
                    end
                end
            endcase
            if (op == 6'h00) imm = {rd, imm[10:6], fn};
            run_rec(model({op, rs, rt, imm}, lat, $urandom()));
        end

`ifdef RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, 32'(exp_ret));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
